// File: rtl/pc_sequencer_if.sv
// Execution-side bus of the program-counter sequencer: instruction/ALU inputs
// toward the sequencer, PC/phase/stack status back to the core.
interface pc_sequencer_if;
    logic [11:0] instIn;
    logic [1:0]  statusPA;
    logic        skipReq;
    logic        pclWe;
    logic [7:0]  pclData;
    logic [10:0] pcOut;
    logic [1:0]  qPhase;
    logic        fetchEn;
    logic        flushOut;
    logic [1:0]  stackDepth;
    logic        stackOvf;
    logic        stackUnf;

    modport master (
        output instIn, statusPA, skipReq, pclWe, pclData,
        input  pcOut, qPhase, fetchEn, flushOut, stackDepth, stackOvf, stackUnf
    );

    modport slave (
        input  instIn, statusPA, skipReq, pclWe, pclData,
        output pcOut, qPhase, fetchEn, flushOut, stackDepth, stackOvf, stackUnf
    );
endinterface

// File: rtl/pc_sequencer.sv
// Four-phase program counter sequencer with a two-level return stack.
// The PC increments at the end of Q1; flow changes are applied at the end of Q4.
module pc_sequencer #(
    parameter logic [10:0] RESET_VECTOR = 11'h7FF
) (
    input  logic            clk,
    input  logic            rst,
    pc_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {
        PH_Q1 = 2'b00,
        PH_Q2 = 2'b01,
        PH_Q3 = 2'b10,
        PH_Q4 = 2'b11
    } phase_t;

    phase_t      r_phase;
    logic [10:0] r_pc;
    logic        r_hold;
    logic        r_flush;
    logic        r_fetch;
    logic [10:0] r_stack1;
    logic [10:0] r_stack2;
    logic [1:0]  r_depth;
    logic        r_ovf;
    logic        r_unf;

    phase_t      w_phase_nxt;
    logic [10:0] w_pc_nxt;
    logic        w_hold_nxt;
    logic        w_flush_nxt;
    logic [10:0] w_stack1_nxt;
    logic [10:0] w_stack2_nxt;
    logic [1:0]  w_depth_nxt;
    logic        w_ovf_nxt;
    logic        w_unf_nxt;

    logic        w_is_goto;
    logic        w_is_call;
    logic        w_is_ret;

    assign w_is_goto = (bus.instIn[11:9] == 3'b101);
    assign w_is_call = (bus.instIn[11:8] == 4'b1001);
    assign w_is_ret  = (bus.instIn[11:8] == 4'b1000);

    // Next-state: phase rotation, Q1 increment, Q4 flow decode with priority
    always_comb begin
        w_phase_nxt  = r_phase;
        w_pc_nxt     = r_pc;
        w_hold_nxt   = r_hold;
        w_flush_nxt  = r_flush;
        w_stack1_nxt = r_stack1;
        w_stack2_nxt = r_stack2;
        w_depth_nxt  = r_depth;
        w_ovf_nxt    = r_ovf;
        w_unf_nxt    = r_unf;
        case (r_phase)
            PH_Q1: begin
                w_phase_nxt = PH_Q2;
                w_hold_nxt  = 1'b0;
                if (r_hold) begin
                    w_pc_nxt = r_pc;
                end else begin
                    w_pc_nxt = r_pc + 11'd1;
                end
            end
            PH_Q2: begin
                w_phase_nxt = PH_Q3;
            end
            PH_Q3: begin
                w_phase_nxt = PH_Q4;
            end
            PH_Q4: begin
                w_phase_nxt = PH_Q1;
                // A flushed instruction is a NOP: it only retires the flush.
                if (r_flush) begin
                    w_flush_nxt = 1'b0;
                end else if (w_is_goto) begin
                    w_pc_nxt    = {bus.statusPA, bus.instIn[8:0]};
                    w_hold_nxt  = 1'b1;
                    w_flush_nxt = 1'b1;
                end else if (w_is_call) begin
                    w_pc_nxt     = {bus.statusPA, 1'b0, bus.instIn[7:0]};
                    w_hold_nxt   = 1'b1;
                    w_flush_nxt  = 1'b1;
                    w_stack2_nxt = r_stack1;
                    w_stack1_nxt = r_pc;
                    if (r_depth == 2'd2) begin
                        w_ovf_nxt = 1'b1;
                    end else begin
                        w_depth_nxt = r_depth + 2'd1;
                    end
                end else if (w_is_ret) begin
                    w_pc_nxt     = r_stack1;
                    w_stack1_nxt = r_stack2;
                    w_hold_nxt   = 1'b1;
                    w_flush_nxt  = 1'b1;
                    if (r_depth == 2'd0) begin
                        w_unf_nxt = 1'b1;
                    end else begin
                        w_depth_nxt = r_depth - 2'd1;
                    end
                end else if (bus.pclWe) begin
                    w_pc_nxt    = {bus.statusPA, 1'b0, bus.pclData};
                    w_hold_nxt  = 1'b1;
                    w_flush_nxt = 1'b1;
                end else if (bus.skipReq) begin
                    w_flush_nxt = 1'b1;
                end else begin
                    w_flush_nxt = 1'b0;
                end
            end
            default: begin
                w_phase_nxt = PH_Q1;
            end
        endcase
    end

    // State register; reset parks in Q4 so the first fetch is the reset vector
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_phase  <= PH_Q4;
            r_pc     <= RESET_VECTOR;
            r_hold   <= 1'b0;
            r_flush  <= 1'b1;
            r_fetch  <= 1'b1;
            r_stack1 <= 11'h000;
            r_stack2 <= 11'h000;
            r_depth  <= 2'd0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            r_phase  <= w_phase_nxt;
            r_pc     <= w_pc_nxt;
            r_hold   <= w_hold_nxt;
            r_flush  <= w_flush_nxt;
            r_fetch  <= (w_phase_nxt == PH_Q4);
            r_stack1 <= w_stack1_nxt;
            r_stack2 <= w_stack2_nxt;
            r_depth  <= w_depth_nxt;
            r_ovf    <= w_ovf_nxt;
            r_unf    <= w_unf_nxt;
        end
    end

    assign bus.pcOut      = r_pc;
    assign bus.qPhase     = r_phase;
    assign bus.fetchEn    = r_fetch;
    assign bus.flushOut   = r_flush;
    assign bus.stackDepth = r_depth;
    assign bus.stackOvf   = r_ovf;
    assign bus.stackUnf   = r_unf;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: drives one instruction per Q1..Q4 cycle
// and compares PC, phase, flush and stack status against hand-computed values.
module tb_pc_sequencer;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    logic [10:0] obs_pc_q1;
    logic [10:0] obs_pc_q2;
    logic [10:0] obs_pc_q4;
    logic        obs_flush;
    logic        obs_fetch;
    logic [1:0]  obs_phase;

    localparam logic [11:0] NOP   = 12'h000;
    localparam logic [11:0] RETLW = 12'h800;
    localparam logic [11:0] CALL  = 12'h950;

    pc_sequencer_if bus ();

    pc_sequencer #(.RESET_VECTOR(11'h7FF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.instIn   = NOP;
        bus.statusPA = 2'b00;
        bus.skipReq  = 1'b0;
        bus.pclWe    = 1'b0;
        bus.pclData  = 8'h00;
    endtask

    // Starts just after the edge entering Q1, ends just after the next one.
    task automatic run_cycle(input logic [11:0] inst, input logic [1:0] pa, input logic skip,
                             input logic we, input logic [7:0] data, input logic noise);
        if (noise) begin
            bus.instIn   = 12'hA00;
            bus.statusPA = 2'b11;
            bus.skipReq  = 1'b1;
            bus.pclWe    = 1'b1;
            bus.pclData  = 8'hFF;
        end else begin
            idle_inputs();
        end
        obs_pc_q1 = bus.pcOut;
        tick();
        obs_pc_q2 = bus.pcOut;
        tick();
        tick();
        bus.instIn   = inst;
        bus.statusPA = pa;
        bus.skipReq  = skip;
        bus.pclWe    = we;
        bus.pclData  = data;
        #1;
        obs_pc_q4 = bus.pcOut;
        obs_flush = bus.flushOut;
        obs_fetch = bus.fetchEn;
        obs_phase = bus.qPhase;
        tick();
        idle_inputs();
    endtask

    task automatic nop_cycle();
        run_cycle(NOP, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    // GOTO plus its flushed follower; the cycle after has pc=t+1 at Q4.
    task automatic goto_to(input logic [10:0] t);
        run_cycle({3'b101, t[8:0]}, t[10:9], 1'b0, 1'b0, 8'h00, 1'b0);
        nop_cycle();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_pc", 16'(bus.pcOut), 16'h07FF);
        check_val("rst_phase", 16'(bus.qPhase), 16'h0003);
        check_val("rst_fetch", 16'(bus.fetchEn), 16'h0001);
        check_val("rst_flush", 16'(bus.flushOut), 16'h0001);
        check_val("rst_depth", 16'(bus.stackDepth), 16'h0000);
        check_val("rst_flags", 16'({bus.stackOvf, bus.stackUnf}), 16'h0000);

        rst = 1'b1;
        tick();
        check_val("rel_phase", 16'(bus.qPhase), 16'h0000);
        check_val("rel_pc", 16'(bus.pcOut), 16'h07FF);
        check_val("rel_flush", 16'(bus.flushOut), 16'h0000);
        check_val("rel_fetch", 16'(bus.fetchEn), 16'h0000);
        nop_cycle();
        check_val("wrap_q2", 16'(obs_pc_q2), 16'h0000);
        check_val("q4_phase", 16'(obs_phase), 16'h0003);
        check_val("q4_fetch", 16'(obs_fetch), 16'h0001);
        nop_cycle();
        check_val("inc_q2", 16'(obs_pc_q2), 16'h0001);

        // Flow requests outside Q4 must be ignored
        run_cycle(NOP, 2'b00, 1'b0, 1'b0, 8'h00, 1'b1);
        check_val("noise_pc", 16'(obs_pc_q2), 16'h0002);
        nop_cycle();
        check_val("noise_flush", 16'(obs_flush), 16'h0000);
        check_val("noise_next", 16'(obs_pc_q2), 16'h0003);

        goto_to(11'h7FE);
        check_val("g7fe_q4", 16'(obs_pc_q4), 16'h07FE);
        nop_cycle();
        check_val("pc_7ff", 16'(obs_pc_q2), 16'h07FF);
        nop_cycle();
        check_val("pc_wrap", 16'(obs_pc_q2), 16'h0000);

        goto_to(11'h00F);
        run_cycle(12'hA55, 2'b01, 1'b0, 1'b0, 8'h00, 1'b0);
        check_val("goto_at", 16'(obs_pc_q4), 16'h0010);
        check_val("goto_nf", 16'(obs_flush), 16'h0000);
        nop_cycle();
        check_val("goto_q1", 16'(obs_pc_q1), 16'h0255);
        check_val("goto_q2", 16'(obs_pc_q2), 16'h0255);
        check_val("goto_q4", 16'(obs_pc_q4), 16'h0255);
        check_val("goto_fl", 16'(obs_flush), 16'h0001);
        nop_cycle();
        check_val("goto_inc", 16'(obs_pc_q2), 16'h0256);
        check_val("goto_fl0", 16'(obs_flush), 16'h0000);

        goto_to(11'h030);
        run_cycle(12'h920, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0);
        check_val("call_at", 16'(obs_pc_q4), 16'h0031);
        check_val("call_dep", 16'(bus.stackDepth), 16'h0001);
        nop_cycle();
        check_val("call_pc", 16'(obs_pc_q4), 16'h0020);
        run_cycle(RETLW, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0);
        check_val("ret_at", 16'(obs_pc_q4), 16'h0021);
        nop_cycle();
        check_val("ret_pc", 16'(obs_pc_q4), 16'h0031);
        check_val("ret_dep", 16'(bus.stackDepth), 16'h0000);

        goto_to(11'h100);
        run_cycle(CALL, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0);
        nop_cycle();
        goto_to(11'h200);
        run_cycle(CALL, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0);
        nop_cycle();
        goto_to(11'h300);
        run_cycle(CALL, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0);
        nop_cycle();
        check_val("nest_dep", 16'(bus.stackDepth), 16'h0002);
        check_val("nest_ovf", 16'(bus.stackOvf), 16'h0001);
        check_val("nest_unf", 16'(bus.stackUnf), 16'h0000);
        run_cycle(RETLW, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0);
        nop_cycle();
        check_val("pop1", 16'(obs_pc_q4), 16'h0301);
        run_cycle(RETLW, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0);
        nop_cycle();
        check_val("pop2", 16'(obs_pc_q4), 16'h0201);
        check_val("pop2_unf", 16'(bus.stackUnf), 16'h0000);
        run_cycle(RETLW, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0);
        nop_cycle();
        check_val("pop3", 16'(obs_pc_q4), 16'h0201);
        check_val("pop3_unf", 16'(bus.stackUnf), 16'h0001);
        check_val("pop3_dep", 16'(bus.stackDepth), 16'h0000);
        check_val("ovf_sticky", 16'(bus.stackOvf), 16'h0001);

        goto_to(11'h040);
        run_cycle(NOP, 2'b00, 1'b1, 1'b0, 8'h00, 1'b0);
        check_val("skip_at", 16'(obs_pc_q4), 16'h0041);
        run_cycle(NOP, 2'b00, 1'b1, 1'b0, 8'h00, 1'b0);
        check_val("skip_fl", 16'(obs_flush), 16'h0001);
        check_val("skip_q2", 16'(obs_pc_q2), 16'h0042);
        check_val("skip_q4", 16'(obs_pc_q4), 16'h0042);
        nop_cycle();
        check_val("skip_fl0", 16'(obs_flush), 16'h0000);
        check_val("skip_next", 16'(obs_pc_q2), 16'h0043);

        // PCL write outranks a simultaneous skip
        run_cycle(NOP, 2'b01, 1'b1, 1'b1, 8'h34, 1'b0);
        nop_cycle();
        check_val("pcl_q2", 16'(obs_pc_q2), 16'h0234);
        check_val("pcl_fl", 16'(obs_flush), 16'h0001);
        nop_cycle();
        check_val("pcl_inc", 16'(obs_pc_q2), 16'h0235);

        run_cycle(12'hA00, 2'b10, 1'b0, 1'b1, 8'h80, 1'b0);
        nop_cycle();
        check_val("prio_goto", 16'(obs_pc_q4), 16'h0400);
        run_cycle(CALL, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0);
        check_val("pre_rst_dep", 16'(bus.stackDepth), 16'h0001);
        tick();
        rst = 1'b0;
        #2;
        check_val("mid_rst_pc", 16'(bus.pcOut), 16'h07FF);
        check_val("mid_rst_ph", 16'(bus.qPhase), 16'h0003);
        check_val("mid_rst_dep", 16'(bus.stackDepth), 16'h0000);
        check_val("mid_rst_fl", 16'(bus.flushOut), 16'h0001);
        check_val("mid_rst_flags", 16'({bus.stackOvf, bus.stackUnf}), 16'h0000);
        tick();
        rst = 1'b1;
        tick();
        check_val("rel2_phase", 16'(bus.qPhase), 16'h0000);
        check_val("rel2_pc", 16'(bus.pcOut), 16'h07FF);
        nop_cycle();
        check_val("rel2_q2", 16'(obs_pc_q2), 16'h0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter: RESET_VECTOR, default 11'h7FF, PC load value at reset.
REQ-002 Port clk  input  1  clock.
REQ-003 Port rst  input  1  reset, asynchronous, active-low.
REQ-004 Port instIn  input  12  instruction in execution; stable Q1-Q4.
REQ-005 Port statusPA  input  2  STATUS page bits PA[1:0], valid at Q4.
REQ-006 Port skipReq  input  1  skip request from the ALU or bit test, sampled at Q4 only.
REQ-007 Port pclWe  input  1  ALU write to PCL, sampled at Q4 only.
REQ-008 Port pclData  input  8  PCL write data.
REQ-009 Port pcOut  output  11  program counter; the program memory fetch address.
REQ-010 Port qPhase  output  2  quadrature phase: 00 Q1, 01 Q2, 10 Q3, 11 Q4.
REQ-011 Port fetchEn  output  1  high in Q4; instruction register load enable.
REQ-012 Port flushOut  output  1  current instruction executes as a NOP.
REQ-013 Port stackDepth  output  2  occupied stack levels, 0 to 2.
REQ-014 Port stackOvf  output  1  sticky stack-overflow flag.
REQ-015 Port stackUnf  output  1  sticky stack-underflow flag.

Function
REQ-016 qPhase SHALL advance one step per clk: Q1, Q2, Q3, Q4, then Q1; fetchEn SHALL equal (qPhase==Q4).
REQ-017 At the Q1 edge (end of Q1), pcOut SHALL increment modulo 2^11 unless holdInc is set; holdInc SHALL clear at that same edge.
REQ-018 All flow actions SHALL take effect at the Q4 edge (end of Q4) and SHALL be suppressed when flushOut=1.
REQ-019 GOTO (instIn[11:9]=101) SHALL set pcOut={statusPA,instIn[8:0]}, holdInc=1, and flush=1.
REQ-020 CALL (instIn[11:8]=1001) SHALL push the current pcOut, set pcOut={statusPA,1'b0,instIn[7:0]}, holdInc=1, and flush=1.
REQ-021 RETLW (instIn[11:8]=1000) SHALL pop: pcOut=stack1, stack1=stack2, stack2 unchanged, holdInc=1, and flush=1.
REQ-022 pclWe=1 with a non-flow instruction SHALL set pcOut={statusPA,1'b0,pclData}, holdInc=1, and flush=1.
REQ-023 skipReq=1 with a non-flow instruction and pclWe=0 SHALL set flush=1 only; the PC increment is not held.
REQ-024 Priority: GOTO/CALL/RETLW > pclWe > skipReq; a lower-priority request SHALL be ignored when a higher one is present.
REQ-025 Flush SHALL clear at the Q4 edge of the flushed cycle; a flushed instruction SHALL never cause a flush, so flushOut never stays high for two consecutive cycles.
REQ-026 Stack push: stack2=stack1, stack1=pcOut, depth=min(depth+1,2).
REQ-027 A push at depth 2 SHALL discard stack2 and set stackOvf.
REQ-028 Stack pop: depth=max(depth-1,0).
REQ-029 A pop at depth 0 SHALL still load pcOut from stack1 and set stackUnf.
REQ-030 stackOvf and stackUnf SHALL clear only on reset.
REQ-031 All instIn, skipReq, and pclWe values outside Q4 SHALL be ignored.

Reset
REQ-032 On rst low, regardless of phase, the block SHALL set pcOut=RESET_VECTOR, qPhase=Q4, flushOut=1, holdInc=0, stack1=stack2=0, stackDepth=0, and stackOvf=stackUnf=0.
REQ-033 After rst releases, the first Q4 SHALL fetch from RESET_VECTOR, and the next cycle SHALL start at Q1 with pcOut wrapping to 11'h000 and flushOut=0.
REQ-034 Reset asserted mid-cycle SHALL abandon any pending flow action.

Verification
REQ-035 Release reset with 12'h000 (NOP) stream -> pcOut 7FF at Q4, 000 at next Q2, then +1 per cycle; wraps 7FF->000.
REQ-036 At pcOut=010, GOTO 12'hA55 with PA=2'b01 -> next cycle flushOut=1 with pcOut=255 held through Q1, fetch 255 at Q4; following Q2 pcOut=256 with flushOut=0.
REQ-037 CALL 12'h920 at pcOut=031 with PA=00, then RETLW -> stack1=031 and depth=1 after CALL, pcOut=020; after RETLW pcOut=031 and depth=0.
REQ-038 Three nested CALLs from 100, 200, and 300 (pushes 101, 201, 301) -> stackOvf=1, depth=2, stack1=301, stack2=201; then three RETLWs -> PC 301, 201, 201, and stackUnf=1.
REQ-039 skipReq=1 at Q4 with pcOut=041 -> next cycle flushOut=1 and PC increments normally to 042, fetch 042; skipReq=1 during that flushed cycle -> no effect.
REQ-040 pclWe=1 with pclData=8'h80 and PA=10 together with GOTO 12'hA00 -> GOTO wins, pcOut=400; rst pulsed at Q2 -> pcOut=7FF, qPhase=Q4, depth=0.
